uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Transmit-side controller between the Wishbone register bank and the UART transmit frontend.
- Buffers bytes written by software in a small FIFO and launches one frame at a time on the frontend (transmit/data out, done back).
- Reports FIFO level, busy, overflow and transmit-empty status to the register bank.

Parameters:
FIFO_DEPTH, 8, number of byte entries; power of two, >= 2
LVL_W, $clog2(FIFO_DEPTH)+1, width of level_o (derived; not overridden)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
wr_i  in  1  push wr_data_i into FIFO (one-cycle strobe)
wr_data_i  in  8  byte to transmit
flush_i  in  1  discard all queued bytes
enable_i  in  1  transmitter enable; gates new frame launches only
ovf_clr_i  in  1  clears overflow_o
done_i  in  1  frontend end-of-frame pulse
transmit_o  out  1  one-cycle launch strobe to frontend
dr_o  out  8  byte to frontend
busy_o  out  1  frame in flight
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
level_o  out  LVL_W  FIFO occupancy, 0..FIFO_DEPTH
overflow_o  out  1  sticky: write dropped
txe_o  out  1  one-cycle pulse: last frame finished with FIFO empty

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, state IDLE, transmit_o=0, dr_o=0, busy_o=0, full_o=0, empty_o=1, level_o=0, overflow_o=0, txe_o=0.
- FIFO: circular buffer, pointers one bit wider than the index.
  - full_o, empty_o and level_o derive from registered pointers.
  - Write sampled at edge E is visible (empty_o=0) after E.
- Write with full_o=1 is dropped and sets overflow_o, even if a pop occurs the same cycle.
- overflow_o clears on ovf_clr_i. If a set and a clear coincide, the set wins.
- flush_i: both pointers reset in one cycle.
  - A write in the same cycle is dropped without setting overflow.
  - An in-flight frame is not aborted; busy_o stays 1 until done_i.
- FSM states: IDLE, WAIT_DONE.
  - IDLE: if enable_i && !empty_o (and launch permitted), pop head; at that edge dr_o<=head, transmit_o<=1, busy_o<=1, state<=WAIT_DONE.
  - WAIT_DONE: transmit_o returns to 0 after one cycle. dr_o is held stable until done_i.
    - On done_i with enable_i && !empty_o (and launch permitted): pop next byte, transmit_o<=1 at that same edge, stay in WAIT_DONE. This is back-to-back with zero idle cycles.
    - On done_i otherwise: state<=IDLE, busy_o<=0. If the FIFO is empty at that edge, txe_o<=1 for one cycle.
- Latency: wr_i into an empty, enabled, idle controller at edge E0 gives transmit_o high in the cycle after E1 (2 edges).
- done_i in IDLE is ignored.
- transmit_o is never asserted while a frame is in flight.
- enable_i low: the current frame completes and no further launches occur. Bytes stay queued.
- Pop and write in the same cycle (not full): both take effect; level_o is unchanged.
- Pointer wrap: indices wrap modulo FIFO_DEPTH; the MSB toggles to distinguish full from empty.
- flush coincident with pop: flush wins; the popped byte is still launched.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- Defined:
  - Adds input cts_n_i (1 bit, active-low clear-to-send), synchronized through two flops reset to 1.
  - "Launch permitted" = synchronized cts_n_i == 0.
  - Deasserting CTS mid-frame does not abort the frame; it only blocks the next launch.
- Undefined: port absent; launch is always permitted.

Test Plan:
- Reset, enable_i=1, write 0xA5 -> transmit_o high exactly 1 cycle, 2 edges after write; dr_o=0xA5 until done_i; busy_o 1→0 after done_i; txe_o one pulse.
- Write 0x11,0x22,0x33 back-to-back; done_i after 10 cycles each -> transmit_o the cycle after each done_i; dr_o sequence 0x11,0x22,0x33; single txe_o after the third done.
- FIFO_DEPTH=8, enable_i=0, write 9 bytes -> level_o=8, full_o=1, overflow_o=1, FIFO content unchanged; ovf_clr_i -> overflow_o=0.
- enable_i=0, fill 5 bytes, enable_i=1 then flush_i during the first frame -> level_o=0; busy_o stays 1 until done_i; no further transmit_o; txe_o pulses.
- Fill 8 bytes, assert rst_i mid-frame -> all outputs at reset values immediately (async); after release no transmit_o without new writes.
- UART_TX_CTS_EN: cts_n_i=1 with 2 bytes queued -> no transmit_o; drop cts_n_i -> transmit_o 3 edges later; raise cts_n_i mid-frame -> frame completes, second byte held.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: byte FIFO and frame launcher between the register bank and the UART transmit frontend.
// Define UART_TX_CTS_EN to add the cts_n_i flow-control input.
module uart_tx_ctrl #(
   parameter int FIFO_DEPTH = 8,
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
`ifdef UART_TX_CTS_EN
   input  logic             cts_n_i,
`endif
   input  logic             wr_i,
   input  logic [7:0]       wr_data_i,
   input  logic             flush_i,
   input  logic             enable_i,
   input  logic             ovf_clr_i,
   input  logic             done_i,
   output logic             transmit_o,
   output logic [7:0]       dr_o,
   output logic             busy_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o,
   output logic             overflow_o,
   output logic             txe_o
);
   localparam int IW = LVL_W - 1;
   typedef enum logic {IDLE, WAIT_DONE} state_t;
   state_t state, state_nx;
   logic [7:0] mem [FIFO_DEPTH];
   logic [LVL_W-1:0] wp, rp;
   logic permit, launch, push;
`ifdef UART_TX_CTS_EN
   logic [1:0] cts_s;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cts_s <= 2'b11;
      else cts_s <= {cts_s[0], cts_n_i};
   assign permit = !cts_s[1];
`else
   assign permit = 1'b1;
`endif
   assign level_o = wp - rp;
   assign empty_o = wp == rp;
   assign full_o  = level_o == LVL_W'(FIFO_DEPTH);
   assign busy_o  = state == WAIT_DONE;
   // A launch in WAIT_DONE only happens on done_i, so frames never overlap.
   assign launch  = enable_i && !empty_o && permit && (state == IDLE || done_i);
   assign push    = wr_i && !full_o && !flush_i;
   always_comb begin
      state_nx = state;
      state_nx = launch ? WAIT_DONE : (state == WAIT_DONE && done_i) ? IDLE : state;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk_i)
      if (push) mem[wp[IW-1:0]] <= wr_data_i;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         wp         <= '0;
         rp         <= '0;
         dr_o       <= '0;
         transmit_o <= 1'b0;
         overflow_o <= 1'b0;
         txe_o      <= 1'b0;
      end else begin
         wp         <= flush_i ? '0 : push ? wp + LVL_W'(1) : wp;
         rp         <= flush_i ? '0 : launch ? rp + LVL_W'(1) : rp;
         dr_o       <= launch ? mem[rp[IW-1:0]] : dr_o;
         transmit_o <= launch;
         overflow_o <= (wr_i && full_o && !flush_i) || (overflow_o && !ovf_clr_i);
         txe_o      <= state == WAIT_DONE && done_i && !launch && empty_o;
      end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl (FIFO_DEPTH=8).
module tb_uart_tx_ctrl;
   logic clk = 0, rst = 1;
   logic wr = 0, flush = 0, enable = 0, ovf_clr = 0, done = 0;
   logic [7:0] wr_data = 0;
   logic transmit, busy, full, empty, overflow, txe;
   logic [7:0] dr;
   logic [3:0] level;
   int cmp = 0, fails = 0;
`ifdef UART_TX_CTS_EN
   logic cts_n = 0;
`endif
   always #5 clk = ~clk;
   uart_tx_ctrl #(.FIFO_DEPTH(8)) dut (
      .clk_i(clk), .rst_i(rst),
`ifdef UART_TX_CTS_EN
      .cts_n_i(cts_n),
`endif
      .wr_i(wr), .wr_data_i(wr_data), .flush_i(flush), .enable_i(enable),
      .ovf_clr_i(ovf_clr), .done_i(done), .transmit_o(transmit), .dr_o(dr),
      .busy_o(busy), .full_o(full), .empty_o(empty), .level_o(level),
      .overflow_o(overflow), .txe_o(txe));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2;
      cmp++;
      if ({transmit, dr, busy, full, empty, level, overflow, txe} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset: got tx=%b dr=%h busy=%b full=%b empty=%b lvl=%0d ovf=%b txe=%b, need 0 00 0 0 1 0 0 0",
                  transmit, dr, busy, full, empty, level, overflow, txe);
      end
      tick;
      rst = 0;
      repeat (3) tick;
   endtask

   task automatic test_single;
      enable = 1;
      wr = 1; wr_data = 8'hA5;
      tick;
      wr = 0;
      cmp++;
      if (transmit !== 0 || empty !== 0 || level !== 1) begin
         fails++; $display("FAIL single_e0: tx=%b empty=%b lvl=%0d, need 0 0 1", transmit, empty, level);
      end
      tick;
      cmp++;
      if (transmit !== 1 || dr !== 8'hA5 || busy !== 1 || level !== 0) begin
         fails++; $display("FAIL single_launch: tx=%b dr=%h busy=%b lvl=%0d, need 1 a5 1 0", transmit, dr, busy, level);
      end
      for (int i = 0; i < 4; i++) begin
         tick;
         cmp++;
         if (transmit !== 0 || dr !== 8'hA5 || busy !== 1 || txe !== 0) begin
            fails++; $display("FAIL single_hold: tx=%b dr=%h busy=%b txe=%b, need 0 a5 1 0", transmit, dr, busy, txe);
         end
      end
      done = 1;
      tick;
      done = 0;
      cmp++;
      if (busy !== 0 || txe !== 1 || transmit !== 0) begin
         fails++; $display("FAIL single_done: busy=%b txe=%b tx=%b, need 0 1 0", busy, txe, transmit);
      end
      tick;
      cmp++;
      if (txe !== 0) begin
         fails++; $display("FAIL single_txe_pulse: txe=%b, need 0", txe);
      end
      done = 1;
      tick;
      done = 0;
      cmp++;
      if (txe !== 0 || busy !== 0 || transmit !== 0) begin
         fails++; $display("FAIL idle_done_ignored: txe=%b busy=%b tx=%b, need 0 0 0", txe, busy, transmit);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
      int txe_cnt = 0;
      wr = 1; wr_data = 8'h11;
      tick;
      wr_data = 8'h22;
      tick;
      cmp++;
      if (transmit !== 1 || dr !== 8'h11) begin
         fails++; $display("FAIL b2b_first: tx=%b dr=%h, need 1 11", transmit, dr);
      end
      wr_data = 8'h33;
      tick;
      wr = 0;
      for (int k = 0; k < 3; k++) begin
         repeat (9) begin
            tick;
            if (txe) txe_cnt++;
            cmp++;
            if (transmit !== 0 || dr !== exp[k] || busy !== 1) begin
               fails++; $display("FAIL b2b_hold%0d: tx=%b dr=%h busy=%b, need 0 %h 1", k, transmit, dr, busy, exp[k]);
            end
         end
         done = 1;
         tick;
         done = 0;
         if (txe) txe_cnt++;
         cmp++;
         if (k < 2 && (transmit !== 1 || dr !== exp[k+1] || busy !== 1 || txe !== 0)) begin
            fails++; $display("FAIL b2b_next%0d: tx=%b dr=%h busy=%b txe=%b, need 1 %h 1 0", k, transmit, dr, busy, txe, exp[k+1]);
         end
         if (k == 2 && (transmit !== 0 || busy !== 0 || txe !== 1)) begin
            fails++; $display("FAIL b2b_last: tx=%b busy=%b txe=%b, need 0 0 1", transmit, busy, txe);
         end
      end
      repeat (3) begin
         tick;
         if (txe) txe_cnt++;
      end
      cmp++;
      if (txe_cnt !== 1) begin
         fails++; $display("FAIL b2b_txe_count: got %0d pulses, need 1", txe_cnt);
      end
   endtask

   task automatic test_overflow;
      enable = 0;
      for (int i = 0; i < 9; i++) begin
         wr = 1; wr_data = 8'h40 + 8'(i);
         tick;
      end
      wr = 0;
      cmp++;
      if (level !== 8 || full !== 1 || overflow !== 1 || transmit !== 0) begin
         fails++; $display("FAIL ovf_fill: lvl=%0d full=%b ovf=%b tx=%b, need 8 1 1 0", level, full, overflow, transmit);
      end
      ovf_clr = 1;
      tick;
      ovf_clr = 0;
      cmp++;
      if (overflow !== 0) begin
         fails++; $display("FAIL ovf_clear: ovf=%b, need 0", overflow);
      end
      wr = 1; wr_data = 8'hEE; ovf_clr = 1;
      tick;
      wr = 0; ovf_clr = 0;
      cmp++;
      if (overflow !== 1 || level !== 8) begin
         fails++; $display("FAIL ovf_set_wins: ovf=%b lvl=%0d, need 1 8", overflow, level);
      end
      ovf_clr = 1;
      tick;
      ovf_clr = 0;
      enable = 1;
      tick;
      cmp++;
      if (transmit !== 1 || dr !== 8'h40 || level !== 7 || overflow !== 0) begin
         fails++; $display("FAIL drain0: tx=%b dr=%h lvl=%0d ovf=%b, need 1 40 7 0", transmit, dr, level, overflow);
      end
      for (int i = 1; i < 8; i++) begin
         repeat (2) tick;
         done = 1;
         tick;
         done = 0;
         cmp++;
         if (transmit !== 1 || dr !== 8'h40 + 8'(i) || level !== 4'(7 - i)) begin
            fails++; $display("FAIL drain%0d: tx=%b dr=%h lvl=%0d, need 1 %h %0d", i, transmit, dr, level, 8'h40 + 8'(i), 7 - i);
         end
      end
      repeat (2) tick;
      done = 1;
      tick;
      done = 0;
      cmp++;
      if (busy !== 0 || txe !== 1 || empty !== 1 || transmit !== 0) begin
         fails++; $display("FAIL drain_end: busy=%b txe=%b empty=%b tx=%b, need 0 1 1 0", busy, txe, empty, transmit);
      end
      tick;
   endtask

   task automatic test_flush;
      enable = 0;
      for (int i = 0; i < 5; i++) begin
         wr = 1; wr_data = 8'h51 + 8'(i);
         tick;
      end
      wr = 0;
      enable = 1;
      tick;
      cmp++;
      if (transmit !== 1 || dr !== 8'h51 || level !== 4) begin
         fails++; $display("FAIL flush_launch: tx=%b dr=%h lvl=%0d, need 1 51 4", transmit, dr, level);
      end
      flush = 1;
      tick;
      flush = 0;
      cmp++;
      if (level !== 0 || empty !== 1 || busy !== 1 || dr !== 8'h51) begin
         fails++; $display("FAIL flush_clear: lvl=%0d empty=%b busy=%b dr=%h, need 0 1 1 51", level, empty, busy, dr);
      end
      repeat (3) begin
         tick;
         cmp++;
         if (transmit !== 0 || busy !== 1) begin
            fails++; $display("FAIL flush_hold: tx=%b busy=%b, need 0 1", transmit, busy);
         end
      end
      done = 1;
      tick;
      done = 0;
      cmp++;
      if (busy !== 0 || txe !== 1 || transmit !== 0) begin
         fails++; $display("FAIL flush_done: busy=%b txe=%b tx=%b, need 0 1 0", busy, txe, transmit);
      end
      repeat (2) begin
         tick;
         cmp++;
         if (transmit !== 0) begin
            fails++; $display("FAIL flush_no_tx: tx=%b, need 0", transmit);
         end
      end
      wr = 1; wr_data = 8'h99; flush = 1; enable = 0;
      tick;
      wr = 0; flush = 0;
      cmp++;
      if (empty !== 1 || overflow !== 0) begin
         fails++; $display("FAIL flush_wr_drop: empty=%b ovf=%b, need 1 0", empty, overflow);
      end
   endtask

   task automatic test_async_reset;
      enable = 0;
      for (int i = 0; i < 8; i++) begin
         wr = 1; wr_data = 8'h71 + 8'(i);
         tick;
      end
      wr = 0;
      enable = 1;
      tick;
      #2 rst = 1;
      #1;
      cmp++;
      if ({transmit, dr, busy, full, empty, level, overflow, txe} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL async_reset: got tx=%b dr=%h busy=%b full=%b empty=%b lvl=%0d ovf=%b txe=%b, need 0 00 0 0 1 0 0 0",
                  transmit, dr, busy, full, empty, level, overflow, txe);
      end
      tick;
      rst = 0;
      repeat (5) begin
         tick;
         cmp++;
         if (transmit !== 0 || empty !== 1 || busy !== 0) begin
            fails++; $display("FAIL post_reset: tx=%b empty=%b busy=%b, need 0 1 0", transmit, empty, busy);
         end
      end
   endtask

`ifdef UART_TX_CTS_EN
   task automatic test_cts;
      enable = 1;
      cts_n = 1;
      repeat (3) tick;
      wr = 1; wr_data = 8'h61;
      tick;
      wr_data = 8'h62;
      tick;
      wr = 0;
      repeat (4) begin
         tick;
         cmp++;
         if (transmit !== 0 || level !== 2) begin
            fails++; $display("FAIL cts_block: tx=%b lvl=%0d, need 0 2", transmit, level);
         end
      end
      cts_n = 0;
      repeat (2) begin
         tick;
         cmp++;
         if (transmit !== 0) begin
            fails++; $display("FAIL cts_sync: tx=%b, need 0", transmit);
         end
      end
      tick;
      cmp++;
      if (transmit !== 1 || dr !== 8'h61) begin
         fails++; $display("FAIL cts_launch: tx=%b dr=%h, need 1 61", transmit, dr);
      end
      cts_n = 1;
      repeat (3) tick;
      done = 1;
      tick;
      done = 0;
      cmp++;
      if (transmit !== 0 || busy !== 0 || level !== 1 || txe !== 0) begin
         fails++; $display("FAIL cts_held: tx=%b busy=%b lvl=%0d txe=%b, need 0 0 1 0", transmit, busy, level, txe);
      end
      cts_n = 0;
      repeat (3) tick;
      cmp++;
      if (transmit !== 1 || dr !== 8'h62) begin
         fails++; $display("FAIL cts_second: tx=%b dr=%h, need 1 62", transmit, dr);
      end
      tick;
      done = 1;
      tick;
      done = 0;
      cmp++;
      if (txe !== 1 || busy !== 0) begin
         fails++; $display("FAIL cts_txe: txe=%b busy=%b, need 1 0", txe, busy);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_overflow;
      test_flush;
      test_async_reset;
`ifdef UART_TX_CTS_EN
      repeat (3) tick;
      test_cts;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
      $finish;
   end
endmodule
